// File: rtl/wb_stage_p.sv
// Registered write-back stage: selects ALU / load / PC+PC_INC data, extracts sub-word
// loads, waits for late load data and drives a one-cycle register-file write pulse.
module wb_stage_p #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int PC_INC = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  pc,
    input  logic [RA_W-1:0]  rd_id,
    input  logic             reg_write,
    input  logic [1:0]       wdsel,
    input  logic [2:0]       ld_type,
    input  logic             flush,
    output logic             stall_req,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             fwd_valid,
    output logic [RA_W-1:0]  fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int OFF_W = $clog2(XLEN / 8);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;
    localparam logic [2:0] LD_WU = 3'b110;

    // Sub-word extraction; offset bits below the element size are ignored.
    // The word offset collapses to zero for XLEN=32, so LW/LWU become the full word.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0]  word,
        input logic [OFF_W-1:0] off,
        input logic [2:0]       ld
    );
        logic [OFF_W-1:0] h_off;
        logic [OFF_W-1:0] w_off;
        logic [XLEN-1:0]  b_sh;
        logic [XLEN-1:0]  h_sh;
        logic [XLEN-1:0]  w_sh;
        h_off = off & ~OFF_W'(1);
        w_off = off & ~OFF_W'(3);
        b_sh  = word >> {off, 3'b000};
        h_sh  = word >> {h_off, 3'b000};
        w_sh  = word >> {w_off, 3'b000};
        case (ld)
            LD_B:    return XLEN'($signed(b_sh[7:0]));
            LD_H:    return XLEN'($signed(h_sh[15:0]));
            LD_W:    return XLEN'($signed(w_sh[31:0]));
            LD_BU:   return XLEN'(b_sh[7:0]);
            LD_HU:   return XLEN'(h_sh[15:0]);
            LD_WU:   return XLEN'(w_sh[31:0]);
            default: return word;
        endcase
    endfunction

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [RA_W-1:0]  pend_rd;
    logic             pend_wr;
    logic [2:0]       pend_ld;
    logic [OFF_W-1:0] pend_off;

    logic             accept;
    logic             latch;
    logic             retire;
    logic [RA_W-1:0]  ret_rd;
    logic             ret_wr;
    logic [XLEN-1:0]  ret_data;

    assign in_ready  = (state == S_IDLE);
    assign stall_req = (state == S_WAIT);
    assign accept    = in_valid && in_ready;

    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_waddr;
    assign fwd_data  = rf_wdata;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        retire    = 1'b0;
        ret_rd    = rd_id;
        ret_wr    = reg_write;
        ret_data  = alu_result;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (wdsel == WD_MEM && !mem_rvalid) begin
                        latch     = 1'b1;
                        state_nxt = S_WAIT;
                    end else begin
                        retire = 1'b1;
                        if (wdsel == WD_MEM) begin
                            ret_data = load_extract(mem_rdata, alu_result[OFF_W-1:0], ld_type);
                        end else if (wdsel == WD_PC) begin
                            ret_data = pc + XLEN'(PC_INC);
                        end
                    end
                end
            end
            S_WAIT: begin
                // Flush beats a simultaneous mem_rvalid: the load is squashed.
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (mem_rvalid) begin
                    retire    = 1'b1;
                    ret_rd    = pend_rd;
                    ret_wr    = pend_wr;
                    ret_data  = load_extract(mem_rdata, pend_off, pend_ld);
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pend_rd    <= '0;
            pend_wr    <= 1'b0;
            pend_ld    <= '0;
            pend_off   <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            retire_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                pend_rd  <= rd_id;
                pend_wr  <= reg_write;
                pend_ld  <= ld_type;
                pend_off <= alu_result[OFF_W-1:0];
            end
            // x0 and non-writing instructions still retire, they just never pulse rf_we.
            rf_we <= retire && ret_wr && (ret_rd != '0);
            if (retire) begin
                rf_waddr   <= ret_rd;
                rf_wdata   <= ret_data;
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_p.sv
// Scoreboard bench for wb_stage_p: a 32-bit instance with a 4-bit retire counter
// and a 64-bit instance sharing the same stimulus.
module tb_wb_stage_p;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;
    localparam logic [1:0] WD_RSV = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, mem_rvalid, reg_write, flush;
    logic [63:0] alu_result, mem_rdata, pc;
    logic [4:0]  rd_id;
    logic [1:0]  wdsel;
    logic [2:0]  ld_type;

    logic        d32_in_ready, d32_stall_req, d32_rf_we, d32_fwd_valid;
    logic [4:0]  d32_rf_waddr, d32_fwd_rd;
    logic [31:0] d32_rf_wdata, d32_fwd_data;
    logic [3:0]  d32_retire_cnt;

    logic        d64_in_ready, d64_stall_req, d64_rf_we, d64_fwd_valid;
    logic [4:0]  d64_rf_waddr, d64_fwd_rd;
    logic [63:0] d64_rf_wdata, d64_fwd_data;
    logic [3:0]  d64_retire_cnt;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    int         model_cnt = 0;
    logic [3:0] last_cnt = '0;

    always #5 clk = ~clk;

    wb_stage_p #(.XLEN(32), .RA_W(5), .PC_INC(4), .CNT_W(4)) d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d32_in_ready),
        .alu_result(alu_result[31:0]), .mem_rdata(mem_rdata[31:0]), .mem_rvalid(mem_rvalid),
        .pc(pc[31:0]), .rd_id(rd_id), .reg_write(reg_write), .wdsel(wdsel), .ld_type(ld_type),
        .flush(flush), .stall_req(d32_stall_req), .rf_we(d32_rf_we), .rf_waddr(d32_rf_waddr),
        .rf_wdata(d32_rf_wdata), .fwd_valid(d32_fwd_valid), .fwd_rd(d32_fwd_rd),
        .fwd_data(d32_fwd_data), .retire_cnt(d32_retire_cnt)
    );

    wb_stage_p #(.XLEN(64), .RA_W(5), .PC_INC(4), .CNT_W(4)) d64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d64_in_ready),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .pc(pc), .rd_id(rd_id), .reg_write(reg_write), .wdsel(wdsel), .ld_type(ld_type),
        .flush(flush), .stall_req(d64_stall_req), .rf_we(d64_rf_we), .rf_waddr(d64_rf_waddr),
        .rf_wdata(d64_rf_wdata), .fwd_valid(d64_fwd_valid), .fwd_rd(d64_fwd_rd),
        .fwd_data(d64_fwd_data), .retire_cnt(d64_retire_cnt)
    );

    // Scoreboard: every retirement of the 32-bit instance pops one expectation.
    always @(negedge clk) begin
        if (rst) begin
            last_cnt = '0;
        end else if (d32_retire_cnt !== last_cnt) begin
            checks++;
            if (d32_retire_cnt !== last_cnt + 4'd1) begin
                errors++;
                $display("FAIL cnt_step: retire_cnt=%0d, required %0d", d32_retire_cnt, last_cnt + 4'd1);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_retire: rf_we=%0b rd=%0d with no instruction pending", d32_rf_we, d32_rf_waddr);
            end else begin
                mon_e = exp_q.pop_front();
                if (d32_rf_we !== mon_e.we || d32_rf_waddr !== mon_e.rd ||
                    d32_fwd_valid !== mon_e.we || d32_fwd_rd !== mon_e.rd) begin
                    errors++;
                    $display("FAIL retire_addr: we=%0b rd=%0d fwd_valid=%0b fwd_rd=%0d, required we=%0b rd=%0d",
                             d32_rf_we, d32_rf_waddr, d32_fwd_valid, d32_fwd_rd, mon_e.we, mon_e.rd);
                end
                if (mon_e.we) begin
                    checks++;
                    if (d32_rf_wdata !== mon_e.data || d32_fwd_data !== mon_e.data) begin
                        errors++;
                        $display("FAIL retire_data: rd=%0d wdata=%h fwd_data=%h, required %h",
                                 mon_e.rd, d32_rf_wdata, d32_fwd_data, mon_e.data);
                    end
                end
            end
            last_cnt = d32_retire_cnt;
        end else begin
            checks++;
            if (d32_rf_we !== 1'b0) begin
                errors++;
                $display("FAIL spurious_we: rf_we=%0b with no retirement, required 0", d32_rf_we);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid   = 1'b0;
            mem_rvalid = 1'b0;
            flush      = 1'b0;
        end
    endtask

    task automatic send(input logic [1:0] ws, input logic [2:0] lt, input logic [4:0] rd,
                        input logic rw, input logic [63:0] alu, input logic [63:0] rdata,
                        input logic [63:0] pcv, input logic rv, input logic [31:0] exp32);
        @(negedge clk);
        in_valid   = 1'b1;
        wdsel      = ws;
        ld_type    = lt;
        rd_id      = rd;
        reg_write  = rw;
        alu_result = alu;
        mem_rdata  = rdata;
        pc         = pcv;
        mem_rvalid = rv;
        flush      = 1'b0;
        if (ws != WD_MEM || rv) begin
            exp_q.push_back('{we: rw && (rd != 5'd0), rd: rd, data: exp32});
            model_cnt++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (d32_rf_we !== 1'b0 || d32_rf_waddr !== 5'd0 || d32_rf_wdata !== 32'd0 ||
            d32_retire_cnt !== 4'd0 || d32_stall_req !== 1'b0 || d32_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: we=%0b addr=%0d data=%h cnt=%0d stall=%0b ready=%0b, required 0/0/0/0/0/1",
                     d32_rf_we, d32_rf_waddr, d32_rf_wdata, d32_retire_cnt, d32_stall_req, d32_in_ready);
        end
        #2 rst = 1'b0;
        send(WD_ALU, 3'b000, 5'd4, 1'b1, 64'hA5A5, 64'd0, 64'd0, 1'b0, 32'hA5A5);
        send(WD_MEM, 3'b010, 5'd7, 1'b1, 64'd0, 64'd0, 64'd0, 1'b0, 32'd0);
        idle_cycles(1);
        checks++;
        if (d32_stall_req !== 1'b1 || d32_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_entry: stall=%0b ready=%0b, required 1/0", d32_stall_req, d32_in_ready);
        end
        #2 rst = 1'b1;
        #1;
        model_cnt = 0;
        checks++;
        if (d32_rf_we !== 1'b0 || d32_rf_waddr !== 5'd0 || d32_rf_wdata !== 32'd0 ||
            d32_retire_cnt !== 4'd0 || d32_stall_req !== 1'b0 || d32_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_wait: we=%0b addr=%0d data=%h cnt=%0d stall=%0b ready=%0b, required 0/0/0/0/0/1",
                     d32_rf_we, d32_rf_waddr, d32_rf_wdata, d32_retire_cnt, d32_stall_req, d32_in_ready);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1111_2222;
        idle_cycles(2);
        checks++;
        if (d32_rf_we !== 1'b0 || d32_retire_cnt !== 4'd0 || d32_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_write: we=%0b cnt=%0d ready=%0b, required 0/0/1",
                     d32_rf_we, d32_retire_cnt, d32_in_ready);
        end
    endtask

    task automatic test_back_to_back;
        send(WD_ALU, 3'b000, 5'd5, 1'b1, 64'h1234, 64'd0, 64'd0, 1'b0, 32'h1234);
        @(posedge clk); #1;
        checks++;
        if (d32_rf_we !== 1'b1 || d32_rf_waddr !== 5'd5 || d32_rf_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL b2b_first: we=%0b addr=%0d data=%h, required 1/5/00001234", d32_rf_we, d32_rf_waddr, d32_rf_wdata);
        end
        send(WD_ALU, 3'b000, 5'd6, 1'b1, 64'hFFFF_FFFF, 64'd0, 64'd0, 1'b0, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        checks++;
        if (d32_rf_we !== 1'b1 || d32_rf_waddr !== 5'd6 || d32_rf_wdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL b2b_second: we=%0b addr=%0d data=%h, required 1/6/ffffffff", d32_rf_we, d32_rf_waddr, d32_rf_wdata);
        end
        idle_cycles(1);
        @(posedge clk); #1;
        checks++;
        if (d32_rf_we !== 1'b0 || d32_rf_waddr !== 5'd6 || d32_rf_wdata !== 32'hFFFF_FFFF || d32_retire_cnt !== 4'd2) begin
            errors++;
            $display("FAIL b2b_hold: we=%0b addr=%0d data=%h cnt=%0d, required 0/6/ffffffff/2",
                     d32_rf_we, d32_rf_waddr, d32_rf_wdata, d32_retire_cnt);
        end
    endtask

    task automatic test_jal;
        send(WD_PC, 3'b000, 5'd1, 1'b1, 64'h55, 64'd0, 64'hFC, 1'b0, 32'h100);
        @(posedge clk); #1;
        checks++;
        if (d32_rf_we !== 1'b1 || d32_rf_wdata !== 32'h100) begin
            errors++;
            $display("FAIL jal_link: we=%0b data=%h, required 1/00000100", d32_rf_we, d32_rf_wdata);
        end
        send(WD_PC, 3'b000, 5'd0, 1'b1, 64'h55, 64'd0, 64'hFC, 1'b0, 32'h100);
        @(posedge clk); #1;
        checks++;
        if (d32_rf_we !== 1'b0 || d32_retire_cnt !== 4'(model_cnt)) begin
            errors++;
            $display("FAIL jal_x0: we=%0b cnt=%0d, required 0/%0d", d32_rf_we, d32_retire_cnt, 4'(model_cnt));
        end
        send(WD_RSV, 3'b000, 5'd2, 1'b1, 64'hCAFE, 64'd0, 64'hFC, 1'b0, 32'hCAFE);
        send(WD_ALU, 3'b000, 5'd3, 1'b0, 64'hBEEF, 64'd0, 64'd0, 1'b0, 32'hBEEF);
        idle_cycles(2);
        checks++;
        if (d32_retire_cnt !== 4'(model_cnt)) begin
            errors++;
            $display("FAIL jal_count: cnt=%0d, required %0d", d32_retire_cnt, 4'(model_cnt));
        end
    endtask

    task automatic test_loads;
        logic [2:0]  lts [0:11];
        logic [63:0] offs[0:11];
        logic [31:0] exps[0:11];
        lts  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001,
                 3'b010, 3'b110, 3'b011, 3'b111, 3'b100, 3'b101};
        offs = '{64'd3, 64'd3, 64'd2, 64'd0, 64'd1, 64'd3,
                 64'd2, 64'd0, 64'd1, 64'd0, 64'd0, 64'd2};
        exps = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                 32'h0000_007F, 32'hFFFF_80FF, 32'h80FF_7F01, 32'h80FF_7F01,
                 32'h80FF_7F01, 32'h80FF_7F01, 32'h0000_0001, 32'h0000_80FF};
        for (int i = 0; i < 12; i++) begin
            send(WD_MEM, lts[i], 5'(10 + i), 1'b1, 64'h1000 + offs[i],
                 64'h80FF_7F01, 64'd0, 1'b1, exps[i]);
        end
        idle_cycles(2);
        checks++;
        if (d32_retire_cnt !== 4'(model_cnt)) begin
            errors++;
            $display("FAIL loads_count: cnt=%0d, required %0d", d32_retire_cnt, 4'(model_cnt));
        end
    endtask

    task automatic test_delayed_load;
        send(WD_MEM, 3'b100, 5'd9, 1'b1, 64'h22, 64'd0, 64'd0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (d32_stall_req !== 1'b1 || d32_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL delay_stall%0d: stall=%0b ready=%0b, required 1/0", i, d32_stall_req, d32_in_ready);
            end
            in_valid   = 1'b0;
            alu_result = 64'd0;
            ld_type    = 3'b111;
            mem_rdata  = 64'hDEAD_BEEF;
            mem_rvalid = (i == 2);
            if (i == 2) begin
                exp_q.push_back('{we: 1'b1, rd: 5'd9, data: 32'h0000_00AD});
                model_cnt++;
            end
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        checks++;
        if (d32_in_ready !== 1'b1 || d32_stall_req !== 1'b0 || d32_rf_we !== 1'b1 ||
            d32_rf_waddr !== 5'd9 || d32_rf_wdata !== 32'h0000_00AD) begin
            errors++;
            $display("FAIL delay_done: ready=%0b stall=%0b we=%0b addr=%0d data=%h, required 1/0/1/9/000000ad",
                     d32_in_ready, d32_stall_req, d32_rf_we, d32_rf_waddr, d32_rf_wdata);
        end

        send(WD_MEM, 3'b010, 5'd8, 1'b1, 64'd0, 64'd0, 64'd0, 1'b0, 32'd0);
        idle_cycles(1);
        @(negedge clk);
        flush      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1357_9BDF;
        @(negedge clk);
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        checks++;
        if (d32_in_ready !== 1'b1 || d32_rf_we !== 1'b0 || d32_retire_cnt !== 4'(model_cnt)) begin
            errors++;
            $display("FAIL flush_wait: ready=%0b we=%0b cnt=%0d, required 1/0/%0d",
                     d32_in_ready, d32_rf_we, d32_retire_cnt, 4'(model_cnt));
        end
        @(negedge clk);
        mem_rvalid = 1'b1;
        idle_cycles(1);

        send(WD_ALU, 3'b000, 5'd12, 1'b1, 64'h777, 64'd0, 64'd0, 1'b0, 32'h777);
        flush = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (d32_rf_we !== 1'b1 || d32_rf_waddr !== 5'd12 || d32_rf_wdata !== 32'h777) begin
            errors++;
            $display("FAIL flush_idle: we=%0b addr=%0d data=%h, required 1/12/00000777", d32_rf_we, d32_rf_waddr, d32_rf_wdata);
        end
        idle_cycles(2);
    endtask

    task automatic test_wrap;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_cnt = 0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_before_wrap: %0d expected retirements never seen, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send(WD_ALU, 3'b000, 5'(i + 1), 1'b1, 64'(i * 3), 64'd0, 64'd0, 1'b0, 32'(i * 3));
        end
        idle_cycles(1);
        @(posedge clk); #1;
        checks++;
        if (d32_retire_cnt !== 4'd1) begin
            errors++;
            $display("FAIL cnt_wrap: cnt=%0d, required 1", d32_retire_cnt);
        end
    endtask

    task automatic test_xlen64;
        logic [1:0]  wss [0:5];
        logic [2:0]  lts [0:5];
        logic [63:0] alus[0:5];
        logic [63:0] rdts[0:5];
        logic [63:0] pcs [0:5];
        logic [63:0] e64 [0:5];
        logic [31:0] e32 [0:5];
        wss  = '{WD_MEM, WD_MEM, WD_MEM, WD_MEM, WD_MEM, WD_PC};
        lts  = '{3'b010, 3'b011, 3'b110, 3'b000, 3'b001, 3'b000};
        alus = '{64'd4, 64'd0, 64'd4, 64'd7, 64'd6, 64'd0};
        rdts = '{64'h8000_0000_0000_0000, 64'h1122_3344_5566_7788, 64'h8000_0000_0000_0000,
                 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0};
        pcs  = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC};
        e64  = '{64'hFFFF_FFFF_8000_0000, 64'h1122_3344_5566_7788, 64'h0000_0000_8000_0000,
                 64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_8000, 64'd0};
        e32  = '{32'd0, 32'h5566_7788, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            send(wss[i], lts[i], 5'd3, 1'b1, alus[i], rdts[i], pcs[i], 1'b1, e32[i]);
            @(posedge clk); #1;
            checks++;
            if (d64_rf_we !== 1'b1 || d64_rf_wdata !== e64[i]) begin
                errors++;
                $display("FAIL x64_case%0d: we=%0b data=%h, required 1/%h", i, d64_rf_we, d64_rf_wdata, e64[i]);
            end
        end
        idle_cycles(2);
    endtask

    initial begin
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        reg_write  = 1'b0;
        flush      = 1'b0;
        alu_result = '0;
        mem_rdata  = '0;
        pc         = '0;
        rd_id      = '0;
        wdsel      = '0;
        ld_type    = '0;

        test_reset();
        test_back_to_back();
        test_jal();
        test_loads();
        test_delayed_load();
        test_wrap();
        test_xlen64();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected retirements never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
